// File: rtl/rename_alloc_pkg.sv
// rtl/rename_alloc_pkg.sv - shared rename widths, bundle slot type and helpers
//
// Purpose : widths of the rename stage and the registered slot format.
// Contents: DISPATCH_WIDTH, SIZE_PHYSICAL_LOG, SIZE_RMT_LOG, rename_slot_t,
//           popcount4() used by the free-list compaction.
package rename_alloc_pkg;

  localparam int DISPATCH_WIDTH    = 4;
  localparam int SIZE_PHYSICAL_LOG = 7;
  localparam int SIZE_RMT_LOG      = 5;

  typedef struct packed {
    logic                         valid;
    logic                         need_dest;
    logic [SIZE_RMT_LOG-1:0]      log_dest;
    logic [SIZE_PHYSICAL_LOG-1:0] phy_dest;
  } rename_slot_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/rename_alloc_if.sv
// rtl/rename_alloc_if.sv - decode/free-list/dispatch signal bundle of the rename allocator
//
// Purpose : groups every non-clock, non-reset signal of rename_alloc.
// Modports: master - drives decode bundle, free-list heads and control; sees results
//           slave  - the allocator (rename_alloc)
// Signals : stall_i, recoverFlag_i, flagRecoverEX_i, decValid{k}_i, needDest{k}_i,
//           logDest{k}_i, freeReg{k}_i ({tag,valid}), freeListEmpty_i,
//           reqFreeReg{k}_o, stall_o, outValid{k}_o, outNeedDest{k}_o,
//           outLogDest{k}_o, outPhyDest{k}_o   (k = 0..3)
interface rename_alloc_if;
  import rename_alloc_pkg::*;

  logic stall_i;
  logic recoverFlag_i;
  logic flagRecoverEX_i;
  logic freeListEmpty_i;

  logic decValid0_i, decValid1_i, decValid2_i, decValid3_i;
  logic needDest0_i, needDest1_i, needDest2_i, needDest3_i;
  logic [SIZE_RMT_LOG-1:0]    logDest0_i, logDest1_i, logDest2_i, logDest3_i;
  logic [SIZE_PHYSICAL_LOG:0] freeReg0_i, freeReg1_i, freeReg2_i, freeReg3_i;

  logic reqFreeReg0_o, reqFreeReg1_o, reqFreeReg2_o, reqFreeReg3_o;
  logic stall_o;
  logic outValid0_o, outValid1_o, outValid2_o, outValid3_o;
  logic outNeedDest0_o, outNeedDest1_o, outNeedDest2_o, outNeedDest3_o;
  logic [SIZE_RMT_LOG-1:0]      outLogDest0_o, outLogDest1_o, outLogDest2_o, outLogDest3_o;
  logic [SIZE_PHYSICAL_LOG-1:0] outPhyDest0_o, outPhyDest1_o, outPhyDest2_o, outPhyDest3_o;

  modport master (
    output stall_i, recoverFlag_i, flagRecoverEX_i, freeListEmpty_i,
    output decValid0_i, decValid1_i, decValid2_i, decValid3_i,
    output needDest0_i, needDest1_i, needDest2_i, needDest3_i,
    output logDest0_i, logDest1_i, logDest2_i, logDest3_i,
    output freeReg0_i, freeReg1_i, freeReg2_i, freeReg3_i,
    input  reqFreeReg0_o, reqFreeReg1_o, reqFreeReg2_o, reqFreeReg3_o, stall_o,
    input  outValid0_o, outValid1_o, outValid2_o, outValid3_o,
    input  outNeedDest0_o, outNeedDest1_o, outNeedDest2_o, outNeedDest3_o,
    input  outLogDest0_o, outLogDest1_o, outLogDest2_o, outLogDest3_o,
    input  outPhyDest0_o, outPhyDest1_o, outPhyDest2_o, outPhyDest3_o
  );

  modport slave (
    input  stall_i, recoverFlag_i, flagRecoverEX_i, freeListEmpty_i,
    input  decValid0_i, decValid1_i, decValid2_i, decValid3_i,
    input  needDest0_i, needDest1_i, needDest2_i, needDest3_i,
    input  logDest0_i, logDest1_i, logDest2_i, logDest3_i,
    input  freeReg0_i, freeReg1_i, freeReg2_i, freeReg3_i,
    output reqFreeReg0_o, reqFreeReg1_o, reqFreeReg2_o, reqFreeReg3_o, stall_o,
    output outValid0_o, outValid1_o, outValid2_o, outValid3_o,
    output outNeedDest0_o, outNeedDest1_o, outNeedDest2_o, outNeedDest3_o,
    output outLogDest0_o, outLogDest1_o, outLogDest2_o, outLogDest3_o,
    output outPhyDest0_o, outPhyDest1_o, outPhyDest2_o, outPhyDest3_o
  );

endinterface

// File: rtl/rename_alloc_compact.sv
// rtl/rename_alloc_compact.sv - in-order compaction of free-list heads onto needing slots
//
// Purpose : counts destination-writing slots, hands them consecutive free-list
//           heads in slot order and decides whether the heads cover the bundle.
// Ports   : dec_valid, need_dest - per-slot decode flags
//           free_reg             - free-list heads, bit 0 valid, upper bits tag
//           free_list_empty      - free list cannot supply a full bundle
//           need_cnt             - number of slots needing a destination (0..4)
//           free_ok              - the heads in use are all valid
//           phy_dest             - assigned tag per slot, 0 for non-writing slots
module rename_alloc_compact
  import rename_alloc_pkg::*;
(
  input  logic [3:0]                            dec_valid,
  input  logic [3:0]                            need_dest,
  input  logic [3:0][SIZE_PHYSICAL_LOG:0]       free_reg,
  input  logic                                  free_list_empty,
  output logic [2:0]                            need_cnt,
  output logic                                  free_ok,
  output logic [3:0][SIZE_PHYSICAL_LOG-1:0]     phy_dest
);

  logic [3:0] need;
  logic [2:0] idx;

  assign need     = dec_valid & need_dest;
  assign need_cnt = popcount4(need);

  // Slot k takes head number "count of lower slots that need one".
  always_comb begin
    phy_dest = '0;
    idx      = '0;
    for (int k = 0; k < 4; k++) begin
      if (need[k]) begin
        phy_dest[k] = free_reg[idx[1:0]][SIZE_PHYSICAL_LOG:1];
        idx         = idx + 3'd1;
      end
    end
  end

  // Only the heads that will actually be popped must be valid.
  always_comb begin
    free_ok = 1'b1;
    if (need_cnt != 3'd0 && free_list_empty)
      free_ok = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < need_cnt && !free_reg[j][0])
        free_ok = 1'b0;
    end
  end

endmodule

// File: rtl/rename_alloc.sv
// rtl/rename_alloc.sv - physical destination allocator with one-cycle registered bundle
//
// Purpose : pops physical tags for a 4-wide decoded bundle, all-or-nothing, and
//           registers the renamed bundle for the next stage.
// Ports   : clk, reset (async, active low), bus (rename_alloc_if.slave)
//           perfStallCnt_o - only with RENAME_ALLOC_PERF_EN: saturating count of
//                            cycles stalled because the free list could not supply
// Config  : RENAME_ALLOC_PERF_EN enables the stall performance counter.
module rename_alloc #(
  parameter int DISPATCH_WIDTH    = rename_alloc_pkg::DISPATCH_WIDTH,
  parameter int SIZE_PHYSICAL_LOG = rename_alloc_pkg::SIZE_PHYSICAL_LOG,
  parameter int SIZE_RMT_LOG      = rename_alloc_pkg::SIZE_RMT_LOG
) (
  input  logic          clk,
  input  logic          reset,
  rename_alloc_if.slave bus
`ifdef RENAME_ALLOC_PERF_EN
  ,
  output logic [31:0]   perfStallCnt_o
`endif
);
  import rename_alloc_pkg::rename_slot_t;

  logic [DISPATCH_WIDTH-1:0]                        dec_valid;
  logic [DISPATCH_WIDTH-1:0]                        need_dest;
  logic [DISPATCH_WIDTH-1:0][SIZE_RMT_LOG-1:0]      log_dest;
  logic [DISPATCH_WIDTH-1:0][SIZE_PHYSICAL_LOG:0]   free_reg;
  logic [DISPATCH_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] phy_dest;
  logic [DISPATCH_WIDTH-1:0]                        req;
  logic [2:0]                                       need_cnt;
  logic                                             free_ok;
  logic                                             flush;
  logic                                             any_valid;
  logic                                             advance;
  logic                                             stall_int;
  rename_slot_t                                     out_q [DISPATCH_WIDTH];

  assign dec_valid = {bus.decValid3_i, bus.decValid2_i, bus.decValid1_i, bus.decValid0_i};
  assign need_dest = {bus.needDest3_i, bus.needDest2_i, bus.needDest1_i, bus.needDest0_i};
  assign log_dest  = {bus.logDest3_i, bus.logDest2_i, bus.logDest1_i, bus.logDest0_i};
  assign free_reg  = {bus.freeReg3_i, bus.freeReg2_i, bus.freeReg1_i, bus.freeReg0_i};

  rename_alloc_compact u_compact (
    .dec_valid       (dec_valid),
    .need_dest       (need_dest),
    .free_reg        (free_reg),
    .free_list_empty (bus.freeListEmpty_i),
    .need_cnt        (need_cnt),
    .free_ok         (free_ok),
    .phy_dest        (phy_dest)
  );

  assign flush     = bus.recoverFlag_i | bus.flagRecoverEX_i;
  assign any_valid = |dec_valid;

  // Gating with reset keeps requests and stall quiet while the block is held.
  assign advance   = reset & any_valid & ~bus.stall_i & ~flush & free_ok;
  assign stall_int = reset & any_valid & ~advance;

  // Pop lanes are always the lowest need_cnt lanes.
  always_comb begin
    req = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++)
      req[k] = advance && (3'(k) < need_cnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++)
        out_q[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++)
        out_q[k].valid <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        out_q[k].valid     <= dec_valid[k];
        out_q[k].need_dest <= dec_valid[k] & need_dest[k];
        out_q[k].log_dest  <= log_dest[k];
        out_q[k].phy_dest  <= phy_dest[k];
      end
    end else if (!bus.stall_i) begin
      // Nothing moved forward: emit a bubble instead of repeating the bundle.
      for (int k = 0; k < DISPATCH_WIDTH; k++)
        out_q[k].valid <= 1'b0;
    end
  end

  assign bus.reqFreeReg0_o  = req[0];
  assign bus.reqFreeReg1_o  = req[1];
  assign bus.reqFreeReg2_o  = req[2];
  assign bus.reqFreeReg3_o  = req[3];
  assign bus.stall_o        = stall_int;

  assign bus.outValid0_o    = out_q[0].valid;
  assign bus.outValid1_o    = out_q[1].valid;
  assign bus.outValid2_o    = out_q[2].valid;
  assign bus.outValid3_o    = out_q[3].valid;
  assign bus.outNeedDest0_o = out_q[0].need_dest;
  assign bus.outNeedDest1_o = out_q[1].need_dest;
  assign bus.outNeedDest2_o = out_q[2].need_dest;
  assign bus.outNeedDest3_o = out_q[3].need_dest;
  assign bus.outLogDest0_o  = out_q[0].log_dest;
  assign bus.outLogDest1_o  = out_q[1].log_dest;
  assign bus.outLogDest2_o  = out_q[2].log_dest;
  assign bus.outLogDest3_o  = out_q[3].log_dest;
  assign bus.outPhyDest0_o  = out_q[0].phy_dest;
  assign bus.outPhyDest1_o  = out_q[1].phy_dest;
  assign bus.outPhyDest2_o  = out_q[2].phy_dest;
  assign bus.outPhyDest3_o  = out_q[3].phy_dest;

`ifdef RENAME_ALLOC_PERF_EN
  logic [31:0] perf_cnt;

  // Counts only stalls caused by the free list, not downstream back-pressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      perf_cnt <= '0;
    else if (stall_int && !free_ok && perf_cnt != 32'hFFFF_FFFF)
      perf_cnt <= perf_cnt + 32'd1;
  end

  assign perfStallCnt_o = perf_cnt;
`endif

endmodule

// File: tb/tb_rename_alloc.sv
// tb/tb_rename_alloc.sv - scoreboard testbench for rename_alloc
module tb_rename_alloc;
  import rename_alloc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rename_alloc_if bus();

`ifdef RENAME_ALLOC_PERF_EN
  logic [31:0] perf;
  logic [31:0] perf_m = '0;
`endif

  rename_alloc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef RENAME_ALLOC_PERF_EN
    ,
    .perfStallCnt_o (perf)
`endif
  );

  typedef struct {
    logic [3:0]      v;
    logic [3:0]      nd;
    logic [3:0][4:0] ld;
    logic [3:0][6:0] pd;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0][7:0] mk_fr(input int t0, t1, t2, t3, input logic [3:0] vb);
    logic [3:0][7:0] r;
    r[0] = {7'(t0), vb[0]};
    r[1] = {7'(t1), vb[1]};
    r[2] = {7'(t2), vb[2]};
    r[3] = {7'(t3), vb[3]};
    return r;
  endfunction

  task automatic drive(input logic [3:0] dv, nd, input logic [3:0][4:0] ld,
                       input logic [3:0][7:0] fr, input logic fe, st, rf, fx);
    {bus.decValid3_i, bus.decValid2_i, bus.decValid1_i, bus.decValid0_i} = dv;
    {bus.needDest3_i, bus.needDest2_i, bus.needDest1_i, bus.needDest0_i} = nd;
    {bus.logDest3_i, bus.logDest2_i, bus.logDest1_i, bus.logDest0_i} = ld;
    {bus.freeReg3_i, bus.freeReg2_i, bus.freeReg1_i, bus.freeReg0_i} = fr;
    bus.freeListEmpty_i = fe;
    bus.stall_i = st;
    bus.recoverFlag_i = rf;
    bus.flagRecoverEX_i = fx;
  endtask

  function automatic logic [3:0] obs_req();
    return {bus.reqFreeReg3_o, bus.reqFreeReg2_o, bus.reqFreeReg1_o, bus.reqFreeReg0_o};
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, "_valid"}, {bus.outValid3_o, bus.outValid2_o, bus.outValid1_o, bus.outValid0_o}, e.v);
    chk({tag, "_needdest"}, {bus.outNeedDest3_o, bus.outNeedDest2_o, bus.outNeedDest1_o, bus.outNeedDest0_o}, e.nd);
    chk({tag, "_logdest"}, {bus.outLogDest3_o, bus.outLogDest2_o, bus.outLogDest1_o, bus.outLogDest0_o}, e.ld);
    chk({tag, "_phydest"}, {bus.outPhyDest3_o, bus.outPhyDest2_o, bus.outPhyDest1_o, bus.outPhyDest0_o}, e.pd);
  endtask

  // One cycle: drive, check combinational outputs, push the expected registered
  // bundle, cross the edge, pop and compare.
  task automatic step(input string tag, input logic [3:0] dv, nd, input logic [3:0][4:0] ld,
                      input logic [3:0][7:0] fr, input logic fe, st, rf, fx);
    logic [3:0] need, ereq;
    int cnt, j;
    logic ok, adv, estall;
    exp_t nx, e;
    drive(dv, nd, ld, fr, fe, st, rf, fx);
    #1;
    need = dv & nd;
    cnt = $countones(need);
    ok = !(cnt != 0 && fe);
    for (int i = 0; i < cnt; i++) if (!fr[i][0]) ok = 1'b0;
    adv = (|dv) && !st && !rf && !fx && ok;
    ereq = '0;
    for (int i = 0; i < 4; i++) ereq[i] = adv && (i < cnt);
    estall = (|dv) && !adv;
    chk({tag, "_req"}, obs_req(), ereq);
    chk({tag, "_stall"}, bus.stall_o, estall);
`ifdef RENAME_ALLOC_PERF_EN
    if (estall && !ok && perf_m != 32'hFFFF_FFFF) perf_m = perf_m + 1;
`endif
    nx = m;
    if (rf || fx) nx.v = '0;
    else if (adv) begin
      j = 0;
      for (int k = 0; k < 4; k++) begin
        nx.v[k]  = dv[k];
        nx.nd[k] = need[k];
        nx.ld[k] = ld[k];
        nx.pd[k] = '0;
        if (need[k]) begin
          nx.pd[k] = fr[j][7:1];
          j++;
        end
      end
    end else if (!st) nx.v = '0;
    sb.push_back(nx);
    m = nx;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_outputs(tag, e);
`ifdef RENAME_ALLOC_PERF_EN
    chk({tag, "_perf"}, perf, perf_m);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][4:0] ld_a, ld_b;
    exp_t zero;
    ld_a = {5'd7, 5'd6, 5'd5, 5'd4};
    ld_b = {5'd31, 5'd17, 5'd9, 5'd1};
    zero.v = '0; zero.nd = '0; zero.ld = '0; zero.pd = '0;
    m = zero;

    // Reset held with a full bundle on the inputs.
    drive(4'hF, 4'hF, ld_a, mk_fr(10, 11, 12, 13, 4'hF), 1'b0, 1'b0, 1'b0, 1'b0);
    #22;
    chk("rst_req", obs_req(), 4'h0);
    chk("rst_stall", bus.stall_o, 1'b0);
    check_outputs("rst", zero);
`ifdef RENAME_ALLOC_PERF_EN
    chk("rst_perf", perf, 32'd0);
`endif
    drive(4'h0, 4'h0, ld_a, mk_fr(0, 0, 0, 0, 4'h0), 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    step("full4", 4'hF, 4'hF, ld_a, mk_fr(10, 11, 12, 13, 4'hF), 1'b0, 1'b0, 1'b0, 1'b0);
    step("nd1010", 4'hF, 4'hA, ld_b, mk_fr(20, 21, 99, 98, 4'h3), 1'b0, 1'b0, 1'b0, 1'b0);
    step("empty", 4'hF, 4'h3, ld_a, mk_fr(30, 31, 32, 33, 4'hF), 1'b1, 1'b0, 1'b0, 1'b0);
    step("reload", 4'hF, 4'h5, ld_b, mk_fr(40, 41, 42, 43, 4'hF), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("hold", 4'hF, 4'hF, ld_a, mk_fr(50, 51, 52, 53, 4'hF), 1'b0, 1'b1, 1'b0, 1'b0);
    step("flush_ex", 4'hF, 4'hF, ld_a, mk_fr(50, 51, 52, 53, 4'hF), 1'b0, 1'b1, 1'b0, 1'b1);
    step("load_b", 4'h7, 4'h6, ld_a, mk_fr(60, 61, 62, 63, 4'h3), 1'b0, 1'b0, 1'b0, 1'b0);
    step("recover", 4'hF, 4'h1, ld_b, mk_fr(64, 65, 66, 67, 4'hF), 1'b0, 1'b0, 1'b1, 1'b0);
    step("load_c", 4'hF, 4'h9, ld_b, mk_fr(70, 71, 72, 73, 4'h3), 1'b0, 1'b0, 1'b0, 1'b0);
    step("bubble", 4'h0, 4'hF, ld_a, mk_fr(74, 75, 76, 77, 4'hF), 1'b0, 1'b0, 1'b0, 1'b0);
    step("noneed", 4'hF, 4'h0, ld_a, mk_fr(1, 2, 3, 4, 4'h0), 1'b1, 1'b0, 1'b0, 1'b0);
    step("badhead", 4'hF, 4'h7, ld_b, mk_fr(80, 81, 82, 83, 4'hB), 1'b0, 1'b0, 1'b0, 1'b0);
    step("tailinv", 4'hF, 4'h7, ld_b, mk_fr(84, 85, 86, 87, 4'h7), 1'b0, 1'b0, 1'b0, 1'b0);
    step("partial", 4'h6, 4'hF, ld_a, mk_fr(90, 91, 92, 93, 4'h3), 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a bundle.
    step("pre_rst", 4'hF, 4'hC, ld_a, mk_fr(100, 101, 102, 103, 4'hF), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(4'hF, 4'hF, ld_b, mk_fr(110, 111, 112, 113, 4'hF), 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_req", obs_req(), 4'h0);
    chk("midrst_stall", bus.stall_o, 1'b0);
    check_outputs("midrst", zero);
    m = zero;
`ifdef RENAME_ALLOC_PERF_EN
    perf_m = '0;
`endif
    @(negedge clk);
    reset = 1'b1;
    step("post_rst", 4'hF, 4'hF, ld_b, mk_fr(110, 111, 112, 113, 4'hF), 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [3:0] rdv, rnd, rvb;
      logic [3:0][4:0] rld;
      rdv = 4'($urandom_range(0, 15));
      rnd = 4'($urandom_range(0, 15));
      rld = 20'($urandom);
      for (int k = 0; k < 4; k++) rvb[k] = ($urandom_range(0, 7) != 0);
      step("rand", rdv, rnd, rld,
           mk_fr($urandom_range(1, 127), $urandom_range(1, 127), $urandom_range(1, 127),
                 $urandom_range(1, 127), rvb),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
